// File: rtl/rrg_pkg.sv
// Shared types and arithmetic helpers for the multi-channel ramp/rate generator.
package rrg_pkg;

  typedef enum logic {IDLE, SWEEP} state_e;

  localparam int unsigned XW = 40;
  typedef logic signed [XW-1:0] wide_t;

  function automatic int unsigned brake_width(input int unsigned w);
    return 2 * w + 1;
  endfunction

  function automatic wide_t abs_w1(input wide_t v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic wide_t sat_w(input wide_t v, input int unsigned w);
    wide_t hi;
    wide_t lo;
    hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    lo = -hi - wide_t'(1);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/rrg_step.sv
// Combinational single-channel position/rate step, shared by all channels.
// sat_o exists only when RRG_SAT_STATUS_EN is defined.
module rrg_step
  import rrg_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic signed [W-1:0] yset_i,
  input  logic signed [W-1:0] yis_i,
  input  logic signed [W-1:0] ris_i,
  input  logic        [W-2:0] rmax_i,
  input  logic        [W-2:0] accel_i,
  input  logic        [W-2:0] window_i,
  output logic signed [W-1:0] yis_o,
  output logic signed [W-1:0] ris_o
`ifdef RRG_SAT_STATUS_EN
  ,
  output logic                sat_o
`endif
);

  localparam int unsigned PW = brake_width(W);

  logic signed [W:0]   d;
  logic        [W:0]   abs_d;
  logic        [W:0]   abs_r;
  logic        [PW-1:0] rr;
  logic        [PW-1:0] ad2;
  logic                snap;
  logic                dir_neg;
  logic                same_sign;
  logic                sat;
  logic signed [W+1:0] r_x;
  logic signed [W+1:0] a_x;
  logic signed [W+1:0] t_x;
  logic signed [W+1:0] r_new;
  logic signed [W+1:0] y_sum;

  always_comb begin
    d     = {yset_i[W-1], yset_i} - {yis_i[W-1], yis_i};
    abs_d = (W+1)'(abs_w1(wide_t'(d)));
    abs_r = (W+1)'(abs_w1(wide_t'(ris_i)));
    rr    = PW'(abs_r) * PW'(abs_r);
    ad2   = PW'({accel_i, 1'b0}) * PW'(abs_d);
    snap  = (abs_d <= {2'b00, window_i}) && (abs_r <= {2'b00, accel_i});

    dir_neg   = d[W] || ((d == '0) && !ris_i[W-1] && (ris_i != '0));
    same_sign = dir_neg ? ris_i[W-1] : (!ris_i[W-1] && (ris_i != '0));

    r_x = {{2{ris_i[W-1]}}, ris_i};
    a_x = {3'b000, accel_i};
    t_x = dir_neg ? -$signed({3'b000, rmax_i}) : $signed({3'b000, rmax_i});

    if (same_sign && (rr >= ad2)) begin
      if (ris_i[W-1]) r_new = (r_x < -a_x) ? r_x + a_x : '0;
      else            r_new = (r_x >  a_x) ? r_x - a_x : '0;
    end else if (r_x < t_x) begin
      // above-limit and normal acceleration both step toward dir*rmax without passing it
      r_new = (r_x + a_x > t_x) ? t_x : r_x + a_x;
    end else begin
      r_new = (r_x - a_x < t_x) ? t_x : r_x - a_x;
    end

    y_sum = {{2{yis_i[W-1]}}, yis_i} + r_new;
    sat   = !snap && (sat_w(wide_t'(y_sum), W) != wide_t'(y_sum));
    yis_o = snap ? yset_i : W'(sat_w(wide_t'(y_sum), W));
    ris_o = (snap || sat) ? '0 : r_new[W-1:0];
`ifdef RRG_SAT_STATUS_EN
    sat_o = sat;
`endif
  end

endmodule

// File: rtl/rrg_multi.sv
// Multi-channel ramp/rate generator: one time-shared step unit swept per timepulse.
// Optional RRG_SAT_STATUS_EN adds sticky per-channel saturation flags.
module rrg_multi
  import rrg_pkg::*;
#(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned W        = 16,
  parameter int unsigned CW       = 4
) (
  input  logic                      clk,
  input  logic                      Reset,
  input  logic                      timepulse,
  input  logic [CHANNELS*W-1:0]     yset,
  input  logic [CHANNELS*(W-1)-1:0] rmax,
  input  logic [CHANNELS*(W-1)-1:0] accel,
  input  logic [CHANNELS*(W-1)-1:0] window,
  output logic [CHANNELS*W-1:0]     yis,
  output logic [CHANNELS*W-1:0]     ris,
  output logic [CHANNELS-1:0]       dac_strobe,
  output logic [CHANNELS-1:0]       at_target,
  output logic                      busy,
  output logic                      overrun
`ifdef RRG_SAT_STATUS_EN
  ,
  input  logic [CHANNELS-1:0]       sat_clr,
  output logic [CHANNELS-1:0]       sat_flag
`endif
);

  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [CHANNELS*W-1:0]   yis_q, yis_d, ris_q, ris_d;
  logic [CHANNELS-1:0]     strobe_q, strobe_d, at_q, at_d;
  logic                    over_q, over_d;
  logic signed [W-1:0]     sel_yset, sel_yis, sel_ris, step_y, step_r;
  logic [W-2:0]            sel_rmax, sel_accel, sel_window;
`ifdef RRG_SAT_STATUS_EN
  logic [CHANNELS-1:0]     sat_q, sat_d;
  logic                    step_sat;
`endif

  rrg_step #(.W(W)) u_step (
    .yset_i   (sel_yset),
    .yis_i    (sel_yis),
    .ris_i    (sel_ris),
    .rmax_i   (sel_rmax),
    .accel_i  (sel_accel),
    .window_i (sel_window),
    .yis_o    (step_y),
    .ris_o    (step_r)
`ifdef RRG_SAT_STATUS_EN
    ,
    .sat_o    (step_sat)
`endif
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    yis_d      = yis_q;
    ris_d      = ris_q;
    strobe_d   = '0;
    at_d       = at_q;
    over_d     = over_q;
    sel_yset   = '0;
    sel_yis    = '0;
    sel_ris    = '0;
    sel_rmax   = '0;
    sel_accel  = '0;
    sel_window = '0;
`ifdef RRG_SAT_STATUS_EN
    sat_d      = sat_q & ~sat_clr;
`endif

    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (cnt_q == CW'(k)) begin
        sel_yset   = yset[k*W +: W];
        sel_yis    = yis_q[k*W +: W];
        sel_ris    = ris_q[k*W +: W];
        sel_rmax   = rmax[k*(W-1) +: (W-1)];
        sel_accel  = accel[k*(W-1) +: (W-1)];
        sel_window = window[k*(W-1) +: (W-1)];
      end
    end

    case (state_q)
      IDLE: begin
        if (timepulse) begin
          state_d = SWEEP;
          cnt_d   = '0;
        end
      end
      SWEEP: begin
        if (timepulse) over_d = 1'b1;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
          if (cnt_q == CW'(k)) begin
            yis_d[k*W +: W] = step_y;
            ris_d[k*W +: W] = step_r;
            strobe_d[k]     = 1'b1;
            at_d[k]         = (step_y == sel_yset) && (step_r == '0);
`ifdef RRG_SAT_STATUS_EN
            if (step_sat) sat_d[k] = 1'b1;
`endif
          end
        end
        if (cnt_q == CW'(CHANNELS - 1)) state_d = IDLE;
        else                            cnt_d   = cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      yis_q    <= '0;
      ris_q    <= '0;
      strobe_q <= '0;
      at_q     <= '0;
      over_q   <= 1'b0;
`ifdef RRG_SAT_STATUS_EN
      sat_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      yis_q    <= yis_d;
      ris_q    <= ris_d;
      strobe_q <= strobe_d;
      at_q     <= at_d;
      over_q   <= over_d;
`ifdef RRG_SAT_STATUS_EN
      sat_q    <= sat_d;
`endif
    end
  end

  assign yis        = yis_q;
  assign ris        = ris_q;
  assign dac_strobe = strobe_q;
  assign at_target  = at_q;
  assign busy       = (state_q == SWEEP);
  assign overrun    = over_q;
`ifdef RRG_SAT_STATUS_EN
  assign sat_flag   = sat_q;
`endif

endmodule
